// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: state encoding and coin decoding.
package vend_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CREDIT = 2'd1;
   localparam logic [1:0] ST_VEND   = 2'd2;
   localparam logic [1:0] ST_CHANGE = 2'd3;

   localparam logic [1:0] COIN_5        = 2'b01;
   localparam logic [1:0] COIN_10       = 2'b10;
   localparam logic [1:0] COIN_5_UNITS  = 2'd1;
   localparam logic [1:0] COIN_10_UNITS = 2'd2;

   // Zero units marks an unrecognised coin encoding.
   function automatic logic [1:0] coin_units(input logic [1:0] coin_type);
      logic [1:0] units;
      case (coin_type)
         COIN_5:  units = COIN_5_UNITS;
         COIN_10: units = COIN_10_UNITS;
         default: units = 2'd0;
      endcase
      return units;
   endfunction

endpackage

// File: rtl/vend_price_table.sv
// Per-product price register file: synchronous write, combinational read.
module vend_price_table
   import vend_pkg::*;
#(
   parameter int NUM_PROD = 4,
   parameter int CRED_W   = 4,
   localparam int ID_W    = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ID_W-1:0]   waddr_i,
   input  logic [CRED_W-1:0] wdata_i,
   input  logic [ID_W-1:0]   raddr_i,
   output logic [CRED_W-1:0] rdata_o
);

   logic [CRED_W-1:0] price_q [NUM_PROD];

   // Price storage; reset leaves every product disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PROD; i++) begin
            price_q[i] <= '0;
         end
      end else if (we_i) begin
         price_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = price_q[raddr_i];

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: credit accumulation, selection check,
// dispense handshake, change payout and cancel/timeout refund.
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int NUM_PROD    = 4,
   parameter int CRED_W      = 4,
   parameter int CREDIT_MAX  = 12,
   parameter int TIMEOUT_CYC = 1024,
   localparam int ID_W       = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              coin_valid,
   input  logic [1:0]        coin_type,
   output logic              coin_reject,
   input  logic              sel_valid,
   input  logic [ID_W-1:0]   sel_id,
   output logic              sel_err,
   input  logic              cancel,
   input  logic              cfg_we,
   input  logic [ID_W-1:0]   cfg_addr,
   input  logic [CRED_W-1:0] cfg_price,
   output logic              vend_req,
   output logic [ID_W-1:0]   vend_id,
   input  logic              vend_ack,
   output logic              chg_req,
   input  logic              chg_ack,
   output logic [CRED_W-1:0] credit,
   output logic              busy
);

   localparam int                TO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
   localparam logic [CRED_W:0]   CMAX     = (CRED_W + 1)'(CREDIT_MAX);
   localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

   logic [1:0]        state_q, state_d;
   logic [CRED_W-1:0] credit_q, credit_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [ID_W-1:0]   vend_id_q, vend_id_d;
   logic              coin_reject_q, coin_reject_d;
   logic              sel_err_q, sel_err_d;
   logic              vend_req_q, vend_req_d;
   logic              chg_req_q, chg_req_d;
   logic              busy_q, busy_d;

   logic [CRED_W-1:0] price_s;
   logic [1:0]        units_s;
   logic [CRED_W:0]   sum_s;
   logic              cancel_s;

   vend_price_table #(
      .NUM_PROD (NUM_PROD),
      .CRED_W   (CRED_W)
   ) u_price_table (
      .clk     (clk),
      .rst     (rst),
      .we_i    (cfg_we),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_price),
      .raddr_i (sel_id),
      .rdata_o (price_s)
   );

   assign units_s  = coin_units(coin_type);
   assign sum_s    = {1'b0, credit_q} + {{(CRED_W - 1){1'b0}}, units_s};
   assign cancel_s = cancel && (state_q == ST_CREDIT);

   // Next-state, credit and pulse logic; priority is cancel > select > coin.
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      to_d          = to_q;
      vend_id_d     = vend_id_q;
      coin_reject_d = 1'b0;
      sel_err_d     = 1'b0;
      case (state_q)
         ST_IDLE, ST_CREDIT: begin
            if (cancel_s) begin
               coin_reject_d = coin_valid;
               to_d          = '0;
               state_d       = ST_CHANGE;
            end else if (sel_valid) begin
               coin_reject_d = coin_valid;
               to_d          = '0;
               // Price 0 is a disabled slot; in IDLE credit 0 always fails.
               if ((price_s != '0) && (credit_q >= price_s)) begin
                  credit_d  = credit_q - price_s;
                  vend_id_d = sel_id;
                  state_d   = ST_VEND;
               end else begin
                  sel_err_d = 1'b1;
               end
            end else if (coin_valid) begin
               to_d = '0;
               if ((units_s != 2'd0) && (sum_s <= CMAX)) begin
                  credit_d = sum_s[CRED_W-1:0];
                  state_d  = ST_CREDIT;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end else if (state_q == ST_CREDIT) begin
               if (to_q == TO_LAST) begin
                  to_d    = '0;
                  state_d = ST_CHANGE;
               end else begin
                  to_d = to_q + TO_ONE;
               end
            end else begin
               to_d = '0;
            end
         end
         ST_VEND: begin
            coin_reject_d = coin_valid;
            if (vend_ack) begin
               state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end else begin
               state_d = ST_VEND;
            end
         end
         ST_CHANGE: begin
            coin_reject_d = coin_valid;
            if (credit_q == '0) begin
               state_d = ST_IDLE;
            end else if (chg_ack) begin
               credit_d = credit_q - CRED_ONE;
               state_d  = (credit_q == CRED_ONE) ? ST_IDLE : ST_CHANGE;
            end else begin
               state_d = ST_CHANGE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            credit_d = '0;
            to_d     = '0;
         end
      endcase
      vend_req_d = (state_d == ST_VEND);
      chg_req_d  = (state_d == ST_CHANGE) && (credit_d != '0);
      busy_d     = (state_d == ST_VEND) || (state_d == ST_CHANGE);
   end

   // State and registered outputs; reset aborts any transaction outright.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         credit_q      <= '0;
         to_q          <= '0;
         vend_id_q     <= '0;
         coin_reject_q <= 1'b0;
         sel_err_q     <= 1'b0;
         vend_req_q    <= 1'b0;
         chg_req_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         to_q          <= to_d;
         vend_id_q     <= vend_id_d;
         coin_reject_q <= coin_reject_d;
         sel_err_q     <= sel_err_d;
         vend_req_q    <= vend_req_d;
         chg_req_q     <= chg_req_d;
         busy_q        <= busy_d;
      end
   end

   assign coin_reject = coin_reject_q;
   assign sel_err     = sel_err_q;
   assign vend_req    = vend_req_q;
   assign vend_id     = vend_id_q;
   assign chg_req     = chg_req_q;
   assign credit      = credit_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scenario bench for vend_sequencer: expected output snapshots are queued
// with each stimulus cycle and compared against the sampled outputs.
module tb_vend_sequencer;

   localparam logic [1:0] C5  = 2'b01;
   localparam logic [1:0] C10 = 2'b10;

   typedef struct packed {
      logic       cv;
      logic [1:0] ct;
      logic       sv;
      logic [1:0] sid;
      logic       can;
      logic       va;
      logic       ca;
      logic       we;
      logic [1:0] wa;
      logic [3:0] wp;
   } stim_t;

   typedef struct packed {
      logic       cr;
      logic       se;
      logic       vr;
      logic [1:0] vid;
      logic       chr;
      logic [3:0] cred;
      logic       bsy;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_valid, sel_valid, cancel, cfg_we, vend_ack, chg_ack;
   logic [1:0] coin_type, sel_id, cfg_addr, vend_id;
   logic [3:0] cfg_price, credit;
   logic       coin_reject, sel_err, vend_req, chg_req, busy;

   obs_t  exp_q[$];
   obs_t  got_q[$];
   string tag_q[$];
   int    n_pass  = 0;
   int    n_total = 0;

   vend_sequencer #(
      .NUM_PROD    (4),
      .CRED_W      (4),
      .CREDIT_MAX  (12),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .coin_valid  (coin_valid),
      .coin_type   (coin_type),
      .coin_reject (coin_reject),
      .sel_valid   (sel_valid),
      .sel_id      (sel_id),
      .sel_err     (sel_err),
      .cancel      (cancel),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_price   (cfg_price),
      .vend_req    (vend_req),
      .vend_id     (vend_id),
      .vend_ack    (vend_ack),
      .chg_req     (chg_req),
      .chg_ack     (chg_ack),
      .credit      (credit),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic obs_t ob(input logic cr, input logic se, input logic vr,
                               input logic [1:0] vid, input logic chr,
                               input logic [3:0] cred, input logic bsy);
      obs_t o;
      o.cr = cr; o.se = se; o.vr = vr; o.vid = vid;
      o.chr = chr; o.cred = cred; o.bsy = bsy;
      return o;
   endfunction

   function automatic obs_t obs_now();
      return ob(coin_reject, sel_err, vend_req, vend_id, chg_req, credit, busy);
   endfunction

   function automatic stim_t st_none();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t st_coin(input logic [1:0] ct);
      stim_t s;
      s = '0; s.cv = 1'b1; s.ct = ct;
      return s;
   endfunction

   function automatic stim_t st_sel(input logic [1:0] id);
      stim_t s;
      s = '0; s.sv = 1'b1; s.sid = id;
      return s;
   endfunction

   function automatic stim_t st_cfg(input logic [1:0] a, input logic [3:0] p);
      stim_t s;
      s = '0; s.we = 1'b1; s.wa = a; s.wp = p;
      return s;
   endfunction

   function automatic stim_t st_can();
      stim_t s;
      s = '0; s.can = 1'b1;
      return s;
   endfunction

   function automatic stim_t st_vack();
      stim_t s;
      s = '0; s.va = 1'b1;
      return s;
   endfunction

   function automatic stim_t st_cack();
      stim_t s;
      s = '0; s.ca = 1'b1;
      return s;
   endfunction

   // Drive one cycle of stimulus, queue its expected outcome, sample after the edge.
   task automatic cyc(input stim_t s, input obs_t e, input string tag);
      coin_valid = s.cv;  coin_type = s.ct;
      sel_valid  = s.sv;  sel_id    = s.sid;
      cancel     = s.can; vend_ack  = s.va;  chg_ack = s.ca;
      cfg_we     = s.we;  cfg_addr  = s.wa;  cfg_price = s.wp;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      got_q.push_back(obs_now());
   endtask

   task automatic test_reset();
      obs_t e, g;
      string t;
      rst = 1'b1;
      cyc(st_none(), ob(0, 0, 0, 2'd0, 0, 4'd0, 0), "reset_a");
      cyc(st_coin(C10), ob(0, 0, 0, 2'd0, 0, 4'd0, 0), "reset_b");
      rst = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
         n_total++;
         if (g !== e) $display("FAIL %s: got %b want %b (cr se vr vid chr cred bsy)", t, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_vend_exact();
      obs_t e, g;
      string t;
      cyc(st_cfg(2'd1, 4'd3), ob(0, 0, 0, 2'd0, 0, 4'd0, 0), "cfg_p1");
      cyc(st_coin(C10),       ob(0, 0, 0, 2'd0, 0, 4'd2, 0), "exact_coin10");
      cyc(st_coin(C5),        ob(0, 0, 0, 2'd0, 0, 4'd3, 0), "exact_coin5");
      cyc(st_sel(2'd1),       ob(0, 0, 1, 2'd1, 0, 4'd0, 1), "exact_sel");
      cyc(st_can(),           ob(0, 0, 1, 2'd1, 0, 4'd0, 1), "vend_cancel_ignored");
      cyc(st_vack(),          ob(0, 0, 0, 2'd1, 0, 4'd0, 0), "exact_done");
      cyc(st_cack(),          ob(0, 0, 0, 2'd1, 0, 4'd0, 0), "exact_idle");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
         n_total++;
         if (g !== e) $display("FAIL %s: got %b want %b (cr se vr vid chr cred bsy)", t, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_vend_change();
      obs_t e, g;
      string t;
      cyc(st_cfg(2'd2, 4'd2), ob(0, 0, 0, 2'd1, 0, 4'd0, 0), "cfg_p2");
      cyc(st_coin(C10),       ob(0, 0, 0, 2'd1, 0, 4'd2, 0), "chg_coin_a");
      cyc(st_coin(C10),       ob(0, 0, 0, 2'd1, 0, 4'd4, 0), "chg_coin_b");
      cyc(st_sel(2'd2),       ob(0, 0, 1, 2'd2, 0, 4'd2, 1), "chg_sel");
      cyc(st_coin(C10),       ob(1, 0, 1, 2'd2, 0, 4'd2, 1), "vend_coin_reject");
      cyc(st_vack(),          ob(0, 0, 0, 2'd2, 1, 4'd2, 1), "vend_to_change");
      cyc(st_cack(),          ob(0, 0, 0, 2'd2, 1, 4'd1, 1), "change_ack1");
      cyc(st_cack(),          ob(0, 0, 0, 2'd2, 0, 4'd0, 0), "change_ack2");
      cyc(st_cack(),          ob(0, 0, 0, 2'd2, 0, 4'd0, 0), "change_extra_ack");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
         n_total++;
         if (g !== e) $display("FAIL %s: got %b want %b (cr se vr vid chr cred bsy)", t, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_sel_err();
      obs_t  e, g;
      string t;
      stim_t s;
      cyc(st_cfg(2'd3, 4'd3), ob(0, 0, 0, 2'd2, 0, 4'd0, 0), "cfg_p3");
      cyc(st_sel(2'd1),       ob(0, 1, 0, 2'd2, 0, 4'd0, 0), "sel_in_idle");
      cyc(st_coin(C5),        ob(0, 0, 0, 2'd2, 0, 4'd1, 0), "sel_coin5");
      cyc(st_sel(2'd3),       ob(0, 1, 0, 2'd2, 0, 4'd1, 0), "sel_short");
      cyc(st_sel(2'd0),       ob(0, 1, 0, 2'd2, 0, 4'd1, 0), "sel_disabled");
      s = st_sel(2'd3); s.we = 1'b1; s.wa = 2'd3; s.wp = 4'd1;
      cyc(s,                  ob(0, 1, 0, 2'd2, 0, 4'd1, 0), "sel_old_price");
      cyc(st_sel(2'd3),       ob(0, 0, 1, 2'd3, 0, 4'd0, 1), "sel_new_price");
      cyc(st_vack(),          ob(0, 0, 0, 2'd3, 0, 4'd0, 0), "sel_done");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
         n_total++;
         if (g !== e) $display("FAIL %s: got %b want %b (cr se vr vid chr cred bsy)", t, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_coin_limits();
      obs_t  e, g;
      string t;
      stim_t s;
      for (int i = 1; i <= 5; i++) begin
         cyc(st_coin(C10), ob(0, 0, 0, 2'd3, 0, 4'(2 * i), 0), "fill_coin10");
      end
      cyc(st_coin(C5),    ob(0, 0, 0, 2'd3, 0, 4'd11, 0), "fill_to_11");
      cyc(st_coin(C10),   ob(1, 0, 0, 2'd3, 0, 4'd11, 0), "overflow_reject");
      cyc(st_coin(C5),    ob(0, 0, 0, 2'd3, 0, 4'd12, 0), "fill_to_max");
      cyc(st_coin(2'b11), ob(1, 0, 0, 2'd3, 0, 4'd12, 0), "invalid_11");
      cyc(st_coin(2'b00), ob(1, 0, 0, 2'd3, 0, 4'd12, 0), "invalid_00");
      cyc(st_coin(C5),    ob(1, 0, 0, 2'd3, 0, 4'd12, 0), "max_coin5_reject");
      cyc(st_can(),       ob(0, 0, 0, 2'd3, 1, 4'd12, 1), "cancel_full");
      s = st_cack(); s.cv = 1'b1; s.ct = C10;
      cyc(s,              ob(1, 0, 0, 2'd3, 1, 4'd11, 1), "change_coin_reject");
      cyc(st_none(),      ob(0, 0, 0, 2'd3, 1, 4'd11, 1), "change_hold");
      cyc(st_can(),       ob(0, 0, 0, 2'd3, 1, 4'd11, 1), "change_cancel_ignored");
      for (int k = 10; k >= 0; k--) begin
         cyc(st_cack(), ob(0, 0, 0, 2'd3, (k != 0), 4'(k), (k != 0)), "change_b2b");
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
         n_total++;
         if (g !== e) $display("FAIL %s: got %b want %b (cr se vr vid chr cred bsy)", t, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_cancel_timeout();
      obs_t  e, g;
      string t;
      stim_t s;
      cyc(st_coin(C10), ob(0, 0, 0, 2'd3, 0, 4'd2, 0), "cx_coin10");
      cyc(st_coin(C5),  ob(0, 0, 0, 2'd3, 0, 4'd3, 0), "cx_coin5");
      s = st_can(); s.cv = 1'b1; s.ct = C10;
      cyc(s,            ob(1, 0, 0, 2'd3, 1, 4'd3, 1), "cancel_with_coin");
      cyc(st_cack(),    ob(0, 0, 0, 2'd3, 1, 4'd2, 1), "refund_ack1");
      cyc(st_cack(),    ob(0, 0, 0, 2'd3, 1, 4'd1, 1), "refund_ack2");
      cyc(st_cack(),    ob(0, 0, 0, 2'd3, 0, 4'd0, 0), "refund_ack3");
      cyc(st_can(),     ob(0, 0, 0, 2'd3, 0, 4'd0, 0), "cancel_in_idle");
      cyc(st_coin(C10), ob(0, 0, 0, 2'd3, 0, 4'd2, 0), "to_coin10");
      for (int i = 0; i < 5; i++) begin
         cyc(st_none(), ob(0, 0, 0, 2'd3, 0, 4'd2, 0), "to_idle_pre");
      end
      cyc(st_coin(2'b00), ob(1, 0, 0, 2'd3, 0, 4'd2, 0), "to_counter_clear");
      for (int i = 0; i < 7; i++) begin
         cyc(st_none(), ob(0, 0, 0, 2'd3, 0, 4'd2, 0), "to_idle_wait");
      end
      cyc(st_none(),    ob(0, 0, 0, 2'd3, 1, 4'd2, 1), "to_expire");
      cyc(st_cack(),    ob(0, 0, 0, 2'd3, 1, 4'd1, 1), "to_ack1");
      cyc(st_cack(),    ob(0, 0, 0, 2'd3, 0, 4'd0, 0), "to_ack2");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
         n_total++;
         if (g !== e) $display("FAIL %s: got %b want %b (cr se vr vid chr cred bsy)", t, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midvend();
      obs_t e, g;
      string t;
      cyc(st_coin(C10), ob(0, 0, 0, 2'd3, 0, 4'd2, 0), "rv_coin10");
      cyc(st_coin(C5),  ob(0, 0, 0, 2'd3, 0, 4'd3, 0), "rv_coin5");
      cyc(st_sel(2'd1), ob(0, 0, 1, 2'd1, 0, 4'd0, 1), "rv_sel");
      rst = 1'b1;
      cyc(st_none(),    ob(0, 0, 0, 2'd0, 0, 4'd0, 0), "rv_reset_abort");
      rst = 1'b0;
      cyc(st_coin(C10), ob(0, 0, 0, 2'd0, 0, 4'd2, 0), "rv_coin_after");
      cyc(st_sel(2'd1), ob(0, 1, 0, 2'd0, 0, 4'd2, 0), "rv_price_cleared");
      cyc(st_vack(),    ob(0, 0, 0, 2'd0, 0, 4'd2, 0), "rv_stray_vack");
      cyc(st_can(),     ob(0, 0, 0, 2'd0, 1, 4'd2, 1), "rv_cancel");
      cyc(st_cack(),    ob(0, 0, 0, 2'd0, 1, 4'd1, 1), "rv_ack1");
      cyc(st_cack(),    ob(0, 0, 0, 2'd0, 0, 4'd0, 0), "rv_ack2");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
         n_total++;
         if (g !== e) $display("FAIL %s: got %b want %b (cr se vr vid chr cred bsy)", t, g, e);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      coin_valid = 1'b0; coin_type = 2'b00; sel_valid = 1'b0; sel_id = 2'd0;
      cancel = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_price = 4'd0;
      vend_ack = 1'b0; chg_ack = 1'b0;
      test_reset();
      test_vend_exact();
      test_vend_change();
      test_sel_err();
      test_coin_limits();
      test_cancel_timeout();
      test_reset_midvend();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
